// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem_timer responder: register map, control/status
// bit positions and byte-strobe merge helpers.
package iomem_timer_pkg;

    localparam int PRESCALE_W = 16;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_RELOAD   = 6'h02;
    localparam logic [5:0] OFF_COUNT    = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int STATUS_PEND   = 0;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] byte_merge16(input logic [15:0] old_v,
                                                 input logic [15:0] new_v,
                                                 input logic [1:0]  strb);
        logic [15:0] res;
        res = old_v;
        for (int i = 0; i < 2; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Prescaler: counts 0..limit while enabled and pulses tick on the limit value,
// wrapping to 0; held at 0 while disabled or cleared.
module iomem_timer_prescaler
    import iomem_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] limit_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == limit_i);

    // Next prescaler count; a lowered limit below the current count lets it run on and wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = {PRESCALE_W{1'b0}};
        end else if (tick_o) begin
            cnt_d = {PRESCALE_W{1'b0}};
        end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    // Prescaler count register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= {PRESCALE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer on the iomem_* bus, answering only inside its
// 256-byte window; one-shot/periodic modes with a level interrupt.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic                  sel_s;
    logic                  access_s;
    logic                  write_s;
    logic                  tick_s;
    logic                  expire_s;
    logic                  clr_presc_s;
    logic                  pend_clr_s;
    logic                  unused_addr_s;
    logic [5:0]            offset_s;
    logic [31:0]           rd_val_s;

    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           reload_q, reload_d;
    logic [31:0]           count_q, count_d;
    logic                  pend_q, pend_d;

    // One access per request: the ready cycle itself never starts another one
    assign sel_s         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign access_s      = sel_s && !ready_q;
    assign write_s       = access_s && (iomem_wstrb != 4'b0000);
    assign offset_s      = iomem_addr[7:2];
    assign unused_addr_s = ^iomem_addr[1:0];

    assign expire_s   = tick_s && (count_q == 32'd0);
    assign pend_clr_s = write_s && (offset_s == OFF_STATUS) && iomem_wstrb[0]
                        && iomem_wdata[STATUS_PEND];

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = pend_q && ctrl_q.irq_en;

    iomem_timer_prescaler u_prescaler (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (ctrl_q.en),
        .clr_i   (clr_presc_s),
        .limit_i (prescale_q),
        .tick_o  (tick_s)
    );

    // Register read mux, sampled into rdata on the access edge
    always_comb begin
        rd_val_s = 32'd0;
        case (offset_s)
            OFF_CTRL:     rd_val_s = {29'd0, ctrl_q};
            OFF_PRESCALE: rd_val_s = {16'd0, prescale_q};
            OFF_RELOAD:   rd_val_s = reload_q;
            OFF_COUNT:    rd_val_s = count_q;
            OFF_STATUS:   rd_val_s = {31'd0, pend_q};
            default:      rd_val_s = 32'd0;
        endcase
    end

    // Counter/expiry first, then bus writes override so a written value wins its edge
    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        reload_d    = reload_q;
        count_d     = count_q;
        clr_presc_s = 1'b0;

        if (tick_s && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end else if (expire_s && ctrl_q.periodic) begin
            count_d = reload_q;
        end else if (expire_s) begin
            ctrl_d.en = 1'b0;
        end else begin
            count_d = count_q;
        end

        if (write_s) begin
            case (offset_s)
                OFF_CTRL: begin
                    if (iomem_wstrb[0]) begin
                        ctrl_d      = ctrl_t'(iomem_wdata[2:0]);
                        clr_presc_s = !ctrl_q.en && iomem_wdata[CTRL_EN];
                    end else begin
                        clr_presc_s = 1'b0;
                    end
                end
                OFF_PRESCALE: begin
                    prescale_d = byte_merge16(prescale_q, iomem_wdata[15:0], iomem_wstrb[1:0]);
                end
                OFF_RELOAD: begin
                    reload_d = byte_merge(reload_q, iomem_wdata, iomem_wstrb);
                end
                OFF_COUNT: begin
                    count_d     = byte_merge(count_q, iomem_wdata, iomem_wstrb);
                    clr_presc_s = 1'b1;
                end
                default: begin
                    clr_presc_s = 1'b0;
                end
            endcase
        end else begin
            clr_presc_s = 1'b0;
        end
    end

    // An expiry on the same edge as a STATUS clear keeps PEND set
    always_comb begin
        if (expire_s) begin
            pend_d = 1'b1;
        end else if (pend_clr_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Bus handshake next state
    always_comb begin
        ready_d = access_s;
        if (access_s) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'd0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            ctrl_q     <= ctrl_t'(3'b000);
            prescale_q <= {PRESCALE_W{1'b0}};
            reload_q   <= 32'd0;
            count_q    <= 32'd0;
            pend_q     <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped down-counting timer that is a responder on the SoC's `iomem_*` bus, the external-peripheral port driven by the CPU for addresses at or above 0x0200_0000 that the SoC does not decode internally. It provides a 16-bit prescaler, a 32-bit counter with reload, one-shot and periodic modes, and a level interrupt intended for one of the SoC's external IRQ inputs (irq_5..irq_7). It answers only accesses inside its own 256-byte window, so several such responders can share the bus by OR-ing their ready/rdata.

## Interface
- BASE_ADDR, 32'h0300_0000, window base; bits [7:0] ignored, window = BASE_ADDR[31:8].
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- iomem_valid  in  1  bus request, held until ready
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1, else 0
- irq  out  1  level interrupt = PEND && IRQ_EN

## Operation
- sel = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8]; offset = iomem_addr[7:2].
- Registers (word offsets, byte strobes honoured on writes):
  - 0x00 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE [15:0]: tick every PRESCALE+1 clocks; upper bits read 0.
  - 0x08 RELOAD [31:0].
  - 0x0C COUNT [31:0]: reads current value; write loads counter and clears prescaler.
  - 0x10 STATUS: bit0 PEND; writing 1 to bit0 clears it; write 0 has no effect.
  - Other offsets in window: read 0, writes ignored, still acknowledged.
- Prescaler: counts 0..PRESCALE while EN=1, emits tick on reaching PRESCALE and wraps to 0; held at 0 while EN=0; cleared on EN 0->1 write and on COUNT write.
- On tick: COUNT==0 -> expire: PEND<=1; PERIODIC=1 -> COUNT<=RELOAD; PERIODIC=0 -> EN<=0, COUNT stays 0. Else COUNT<=COUNT-1.
- Periodic expiry interval = (RELOAD+1)*(PRESCALE+1) clocks.
- Accesses outside the window: no ready, rdata stays 0, no state change.

## Timing
- Reset values: iomem_ready=0, iomem_rdata=0, irq=0, all registers and prescaler 0. Reset mid-transaction drops ready immediately; the CPU reissues after reset.
- Handshake: the access is performed at the first rising edge where sel && !iomem_ready. That edge sets iomem_ready=1 and registers rdata, so the latency is one cycle. Next edge iomem_ready=0 regardless of valid; never two consecutive ready cycles.
- Write effects are visible from the edge where ready rises; a read returns the value before that edge.
- irq is combinational from registered PEND and IRQ_EN, so it rises the cycle after the expiring tick.
- Simultaneous events, resolved at the same edge:
  - STATUS clear vs expiry: PEND set wins, so no event is lost.
  - COUNT write vs tick: the write wins, and the prescaler is cleared.
  - CTRL write vs one-shot expiry: the written EN wins, and PEND is still set.
  - RELOAD write vs periodic expiry: COUNT takes the old RELOAD.
- COUNT decrement never wraps below 0; 0 only reloads or stops.

## Structure
- Shared package iomem_timer_pkg: register word offsets (CTRL/PRESCALE/RELOAD/COUNT/STATUS), CTRL bit indices, STATUS_PEND index.
- Sub-module iomem_timer_prescaler: 16-bit counter with enable/clear inputs and tick output.
- Top: bus decode and handshake, register file, counter/expiry logic.

## Test plan
- Reset, then read each of the five registers at 0x0300_0000..0x0300_0010 -> all read 0, ready exactly one cycle after valid each time, irq=0.
- Write 0x0300_0100 (outside window) -> no ready for 20 cycles, rdata 0. Write 0x0300_0020 -> ready after 1 cycle, reads back 0.
- PRESCALE=3, RELOAD=4, CTRL=0x7 -> PEND and irq rise at 20-cycle intervals. Write STATUS=1 -> irq low next cycle and rises again at the next expiry.
- One-shot: COUNT=2, PRESCALE=0, CTRL=0x5 -> expiry 3 cycles later, EN reads 0, COUNT reads 0, PEND=1.
- STATUS=1 write lands on the same edge as an expiry -> PEND remains 1. COUNT=0x100 write coincides with a tick -> COUNT reads 0x100.
- Byte write wstrb=4'b0010, wdata=0xAABBCCDD to RELOAD=0x11223344 -> RELOAD reads 0x1122CC44. Assert resetn low mid-access -> ready deasserts immediately and all registers read 0 after release.
